// File: rtl/arbiter_wrr_iob_if.sv
// Request/grant bundle between bus masters and the weighted round-robin arbiter.
// The master modport drives requests; the slave modport is the arbiter itself.
interface arbiter_wrr_iob_if #(
  parameter int PORTS    = 4,
  parameter int WEIGHT_W = 4
);
  localparam int IW = $clog2(PORTS);

  logic [PORTS-1:0]          request;
  logic [PORTS-1:0]          acknowledge;
  logic [PORTS*WEIGHT_W-1:0] weight;
  logic [PORTS-1:0]          grant;
  logic                      grant_valid;
  logic [IW-1:0]             grant_encoded;
  logic                      timeout;

  modport master (
    output request, acknowledge, weight,
    input  grant, grant_valid, grant_encoded, timeout
  );

  modport slave (
    input  request, acknowledge, weight,
    output grant, grant_valid, grant_encoded, timeout
  );
endinterface

// File: rtl/arbiter_wrr_iob.sv
// Weighted round-robin arbiter with registered outputs.
// Define ARBITER_WRR_WATCHDOG_EN to revoke grants that are never acknowledged.
module arbiter_wrr_iob #(
  parameter int PORTS    = 4,
  parameter int WEIGHT_W = 4,
  parameter int TIMEOUT  = 256
) (
  input  logic               clk,
  input  logic               rst,
  arbiter_wrr_iob_if.slave   bus
);
  localparam int IW = $clog2(PORTS);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       g_q, g_d;
  logic [PORTS-1:0]    grant_q, grant_d;
  logic [WEIGHT_W-1:0] wl_q, wl_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;

  logic                ack_g, req_g, credit_done;
  logic                wd_exp, grant_end, load;
  logic [IW-1:0]       nxt_ptr, sel_ptr;
  logic                any_req, hi_found;
  logic [IW-1:0]       hi_idx, lo_idx, pick;
  logic [WEIGHT_W-1:0] wsel;
  logic [WEIGHT_W:0]   cnt_inc;

  assign ack_g   = bus.acknowledge[g_q];
  assign req_g   = bus.request[g_q];
  assign cnt_inc = {1'b0, cnt_q} + {{WEIGHT_W{1'b0}}, 1'b1};
  assign credit_done = ack_g && (cnt_inc == {1'b0, wl_q});

  assign grant_end = (state_q == S_GRANT) &&
                     (!req_g || credit_done || wd_exp);
  assign nxt_ptr = (g_q == IW'(PORTS - 1)) ? '0 : g_q + 1'b1;
  // On a handover the search starts just past the retiring port.
  assign sel_ptr = (state_q == S_GRANT) ? nxt_ptr : ptr_q;

  always_comb begin
    any_req  = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (bus.request[i] && !any_req) begin
        any_req = 1'b1;
        lo_idx  = IW'(i);
      end
      if (bus.request[i] && !hi_found && IW'(i) >= sel_ptr) begin
        hi_found = 1'b1;
        hi_idx   = IW'(i);
      end
    end
  end

  assign pick = hi_found ? hi_idx : lo_idx;
  assign wsel = bus.weight[int'(pick)*WEIGHT_W +: WEIGHT_W];
  assign load = any_req && ((state_q == S_IDLE) || grant_end);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    grant_d = grant_q;
    wl_d    = wl_q;
    cnt_d   = cnt_q;
    if (grant_end) ptr_d = nxt_ptr;
    if (load) begin
      state_d = S_GRANT;
      g_d     = pick;
      grant_d = PORTS'(1) << pick;
      wl_d    = (wsel == '0) ? WEIGHT_W'(1) : wsel;
      cnt_d   = '0;
    end else if (grant_end) begin
      state_d = S_IDLE;
      g_d     = '0;
      grant_d = '0;
      cnt_d   = '0;
    end else if (state_q == S_GRANT && ack_g) begin
      cnt_d   = cnt_inc[WEIGHT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      grant_q <= '0;
      wl_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      grant_q <= grant_d;
      wl_q    <= wl_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ARBITER_WRR_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_q, wd_d;
  logic          to_q;

  // Fires on the edge that ends the TIMEOUT-th silent grant cycle.
  assign wd_exp = (state_q == S_GRANT) && !ack_g &&
                  (wd_q == TW'(TIMEOUT - 1));

  always_comb begin
    wd_d = '0;
    if (!load && state_q == S_GRANT && !ack_g)
      wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= wd_exp;
    end
  end

  assign bus.timeout = to_q;
`else
  assign wd_exp      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = (state_q == S_GRANT);
  assign bus.grant_encoded = g_q;
endmodule

// File: tb/tb_arbiter_wrr_iob.sv
// Directed vector bench for arbiter_wrr_iob (4 ports, 4-bit weights).
// Expected outputs are hand-derived from the arbitration rules.
module tb_arbiter_wrr_iob;
  logic clk;
  logic rst;

  arbiter_wrr_iob_if #(.PORTS(4), .WEIGHT_W(4)) bus ();

  arbiter_wrr_iob #(.PORTS(4), .WEIGHT_W(4), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [15:0] wt;
    logic [3:0]  eg;
    logic        ev;
    logic [1:0]  ee;
    logic        et;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  int n_chk;
  int n_pass;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] ak,
                              logic [15:0] w, logic [3:0] g, logic v,
                              logic [1:0] e, logic t);
    vec_t x;
    x.rst = r; x.req = rq; x.ack = ak; x.wt = w;
    x.eg = g; x.ev = v; x.ee = e; x.et = t;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(logic r, logic [3:0] rq, logic [3:0] ak,
                       logic [15:0] w);
    @(negedge clk);
    rst = r;
    bus.request = rq;
    bus.acknowledge = ak;
    bus.weight = w;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {24'd0, bus.grant, bus.grant_valid,
            bus.grant_encoded, bus.timeout};
  endfunction

  logic [3:0] exp_seq [11];

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.request = '0;
    bus.acknowledge = '0;
    bus.weight = '0;

    // reset and single request
    tbl[0]  = mk(1, 4'b0000, 4'b0000, 16'h1123, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(1, 4'b0100, 4'b0000, 16'h1123, 4'b0000, 0, 0, 0);
    tbl[2]  = mk(0, 4'b0000, 4'b1111, 16'h1123, 4'b0000, 0, 0, 0);
    tbl[3]  = mk(0, 4'b0100, 4'b0000, 16'h1123, 4'b0100, 1, 2, 0);
    tbl[4]  = mk(0, 4'b0100, 4'b0100, 16'h1123, 4'b0100, 1, 2, 0);
    tbl[5]  = mk(0, 4'b0000, 4'b0000, 16'h1123, 4'b0000, 0, 0, 0);
    // port 1 weight 5, drop after 2 acks, then wrap back to port 1
    tbl[6]  = mk(0, 4'b0010, 4'b0000, 16'h0050, 4'b0010, 1, 1, 0);
    tbl[7]  = mk(0, 4'b1010, 4'b0010, 16'h0050, 4'b0010, 1, 1, 0);
    tbl[8]  = mk(0, 4'b1010, 4'b0010, 16'h0050, 4'b0010, 1, 1, 0);
    tbl[9]  = mk(0, 4'b1000, 4'b0000, 16'h0050, 4'b1000, 1, 3, 0);
    tbl[10] = mk(0, 4'b1010, 4'b1000, 16'h0050, 4'b0010, 1, 1, 0);
    tbl[11] = mk(0, 4'b0000, 4'b0000, 16'h0050, 4'b0000, 0, 0, 0);
    // bring ptr to 3, then wrap with weight[0]=0
    tbl[12] = mk(0, 4'b0100, 4'b0000, 16'h0050, 4'b0100, 1, 2, 0);
    tbl[13] = mk(0, 4'b0000, 4'b0000, 16'h0050, 4'b0000, 0, 0, 0);
    tbl[14] = mk(0, 4'b0011, 4'b0000, 16'h0020, 4'b0001, 1, 0, 0);
    tbl[15] = mk(0, 4'b0011, 4'b0001, 16'h0020, 4'b0010, 1, 1, 0);
    tbl[16] = mk(0, 4'b0011, 4'b0010, 16'h0020, 4'b0010, 1, 1, 0);
    tbl[17] = mk(0, 4'b0011, 4'b0001, 16'h0020, 4'b0010, 1, 1, 0);
    tbl[18] = mk(0, 4'b0011, 4'b0010, 16'h0020, 4'b0001, 1, 0, 0);
    tbl[19] = mk(0, 4'b0000, 4'b0000, 16'h0020, 4'b0000, 0, 0, 0);
    // reset while port 2 holds with cnt=1
    tbl[20] = mk(0, 4'b0100, 4'b0000, 16'h0300, 4'b0100, 1, 2, 0);
    tbl[21] = mk(0, 4'b0100, 4'b0100, 16'h0300, 4'b0100, 1, 2, 0);
    tbl[22] = mk(1, 4'b0101, 4'b0000, 16'h0300, 4'b0000, 0, 0, 0);
    tbl[23] = mk(0, 4'b0101, 4'b0000, 16'h0300, 4'b0001, 1, 0, 0);
    tbl[24] = mk(0, 4'b0000, 4'b0000, 16'h0300, 4'b0000, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].ack, tbl[i].wt);
      chk($sformatf("vec%0d", i), outs(),
          {24'd0, tbl[i].eg, tbl[i].ev, tbl[i].ee, tbl[i].et});
    end

    // weighted sharing: weights 3,2,1,1 on ports 0..3, ack every cycle
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    drive(1, 4'b0000, 4'b0000, 16'h1123);
    for (int k = 0; k < 11; k++) begin
      drive(0, 4'b1111, bus.grant, 16'h1123);
      chk($sformatf("wrr%0d", k),
          {27'd0, bus.grant, bus.grant_valid},
          {27'd0, exp_seq[k], 1'b1});
    end

    // watchdog: port 0 never acknowledged
    drive(1, 4'b0000, 4'b0000, 16'h1111);
    drive(0, 4'b0011, 4'b0000, 16'h1111);
    chk("wd_first", outs(), {24'd0, 4'b0001, 1'b1, 2'd0, 1'b0});
`ifdef ARBITER_WRR_WATCHDOG_EN
    for (int k = 0; k < 7; k++) begin
      drive(0, 4'b0011, 4'b0000, 16'h1111);
      chk($sformatf("wd_hold%0d", k), outs(),
          {24'd0, 4'b0001, 1'b1, 2'd0, 1'b0});
    end
    drive(0, 4'b0011, 4'b0000, 16'h1111);
    chk("wd_revoke", outs(), {24'd0, 4'b0010, 1'b1, 2'd1, 1'b1});
    drive(0, 4'b0011, 4'b0000, 16'h1111);
    chk("wd_pulse_end", outs(), {24'd0, 4'b0010, 1'b1, 2'd1, 1'b0});
`else
    for (int k = 0; k < 110; k++) begin
      drive(0, 4'b0011, 4'b0000, 16'h1111);
      chk($sformatf("nowd_hold%0d", k), outs(),
          {24'd0, 4'b0001, 1'b1, 2'd0, 1'b0});
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
